// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and fetched-instruction counter.
// A one-cycle BOOT state after reset inserts a bubble before the first real fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_taken,
  input  logic [15:0]      br_imm16,
  input  logic [31:0]      br_pc4,
  output logic [31:0]      imem_adr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      ifid_inst,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic {BOOT, RUN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_load;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_target;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = br_pc4 + {{14{br_imm16[15]}}, br_imm16, 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    fetch_load = 1'b0;
    if (state_q == BOOT) begin
      inst_d  = 32'h0000_0000;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (br_taken) begin
      // Squash the wrong-path fetch; ifid_pc4 deliberately keeps its value.
      pc_d    = br_target;
      inst_d  = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (flush) begin
      pc_d    = pc_plus4;
      inst_d  = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      pc_d       = pc_plus4;
      inst_d     = imem_data;
      pc4_d      = pc_plus4;
      valid_d    = 1'b1;
      fetch_load = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fetch_load && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_adr   = pc_q;
  assign ifid_inst  = inst_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: three instances (default, wrapping RESET_PC, 2-bit counter) checked
// every cycle against a behavioural fetch model, plus directed literal expectations.
module tb_if_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, br_taken;
  logic [15:0] br_imm16;
  logic [31:0] br_pc4;
  logic [31:0] adr [3];
  logic [31:0] dat [3];
  logic [31:0] inst [3];
  logic [31:0] pc4 [3];
  logic        valid [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  // Instruction memory: each word holds 32'h1000_0000 + its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign dat[0] = mem(adr[0]);
  assign dat[1] = mem(adr[1]);
  assign dat[2] = mem(adr[2]);

  if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
    .br_imm16(br_imm16), .br_pc4(br_pc4), .imem_adr(adr[0]), .imem_data(dat[0]),
    .ifid_inst(inst[0]), .ifid_pc4(pc4[0]), .ifid_valid(valid[0]), .fetch_cnt(cnt0));
  if_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
    .br_imm16(br_imm16), .br_pc4(br_pc4), .imem_adr(adr[1]), .imem_data(dat[1]),
    .ifid_inst(inst[1]), .ifid_pc4(pc4[1]), .ifid_valid(valid[1]), .fetch_cnt(cnt1));
  if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
    .br_imm16(br_imm16), .br_pc4(br_pc4), .imem_adr(adr[2]), .imem_data(dat[2]),
    .ifid_inst(inst[2]), .ifid_pc4(pc4[2]), .ifid_valid(valid[2]), .fetch_cnt(cnt2));

  function automatic logic [31:0] rpc(input int i);
    return (i == 1) ? 32'hFFFF_FFF8 : 32'h0000_0000;
  endfunction

  function automatic int unsigned cmax(input int i);
    return (i == 2) ? 3 : 65535;
  endfunction

  function automatic logic [31:0] dut_cnt(input int i);
    if (i == 0) return {16'h0, cnt0};
    if (i == 1) return {16'h0, cnt1};
    return {30'h0, cnt2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: what a fetch stage must hold after each edge.
  logic [31:0] m_pc [3];
  logic [31:0] m_inst [3];
  logic [31:0] m_pc4 [3];
  logic        m_valid [3];
  logic        m_boot [3];
  int unsigned m_cnt [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pc[i] = rpc(i); m_inst[i] = 0; m_pc4[i] = 0; m_valid[i] = 0;
        m_boot[i] = 1; m_cnt[i] = 0;
      end else if (m_boot[i]) begin
        m_inst[i] = 0; m_valid[i] = 0; m_boot[i] = 0;
      end else if (br_taken) begin
        m_pc[i] = br_pc4 + 32'($signed(br_imm16) * 4);
        m_inst[i] = 0; m_valid[i] = 0;
      end else if (stall) begin
        m_pc[i] = m_pc[i];
      end else if (flush) begin
        m_pc[i] = m_pc[i] + 4; m_inst[i] = 0; m_valid[i] = 0;
      end else begin
        m_inst[i] = mem(m_pc[i]);
        m_pc4[i] = m_pc[i] + 4;
        m_pc[i] = m_pc[i] + 4;
        m_valid[i] = 1;
        if (m_cnt[i] < cmax(i)) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m_adr%0d", i), adr[i], m_pc[i]);
      chk($sformatf("m_inst%0d", i), inst[i], m_inst[i]);
      chk($sformatf("m_pc4_%0d", i), pc4[i], m_pc4[i]);
      chk($sformatf("m_valid%0d", i), {31'h0, valid[i]}, {31'h0, m_valid[i]});
      chk($sformatf("m_cnt%0d", i), dut_cnt(i), m_cnt[i]);
    end
  end

  logic [31:0] e_inst [3];
  logic [31:0] e_cnt2 [5];
  logic [31:0] h_adr, h_inst, h_cnt;
  bit          reached;

  initial begin
    e_inst = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
    e_cnt2 = '{1, 2, 3, 3, 3};
    rst = 1; stall = 0; flush = 0; br_taken = 0; br_imm16 = 0; br_pc4 = 0;
    repeat (2) @(negedge clk);
    chk("rst_adr0", adr[0], 32'h0);
    chk("rst_adr1", adr[1], 32'hFFFF_FFF8);
    chk("rst_inst0", inst[0], 32'h0);
    chk("rst_cnt0", dut_cnt(0), 32'h0);
    rst = 0;
    @(negedge clk);
    chk("boot_valid0", {31'h0, valid[0]}, 32'h0);
    chk("boot_adr1", adr[1], 32'hFFFF_FFF8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("sat_cnt2_%0d", k), dut_cnt(2), e_cnt2[k]);
      if (k < 3) begin
        chk($sformatf("seq_inst%0d", k), inst[0], e_inst[k]);
        chk($sformatf("seq_pc4_%0d", k), pc4[0], 32'(4 * (k + 1)));
      end
      if (k == 0) chk("wrap_adr_a", adr[1], 32'hFFFF_FFFC);
      if (k == 1) begin
        chk("wrap_adr_b", adr[1], 32'h0000_0000);
        chk("wrap_pc4", pc4[1], 32'h0000_0000);
      end
      if (k == 2) chk("seq_cnt0", dut_cnt(0), 32'd3);
    end
    reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      if (adr[0] == 32'h40) reached = 1;
      else @(negedge clk);
    end
    chk("reach_pc40", adr[0], 32'h40);
    br_taken = 1; br_pc4 = 32'h24; br_imm16 = 16'hFFFC;
    @(negedge clk);
    br_taken = 0;
    chk("br_adr", adr[0], 32'h14);
    chk("br_valid", {31'h0, valid[0]}, 32'h0);
    chk("br_inst", inst[0], 32'h0);
    chk("br_pc4_hold", pc4[0], 32'h40);
    @(negedge clk);
    chk("br_tgt_inst", inst[0], 32'h1000_0014);
    chk("br_tgt_valid", {31'h0, valid[0]}, 32'h1);
    h_adr = adr[0]; h_inst = inst[0]; h_cnt = dut_cnt(0);
    for (int k = 0; k < 3; k++) begin
      stall = 1; flush = (k == 1);
      @(negedge clk);
      chk($sformatf("stall_adr%0d", k), adr[0], h_adr);
      chk($sformatf("stall_inst%0d", k), inst[0], h_inst);
      chk($sformatf("stall_valid%0d", k), {31'h0, valid[0]}, 32'h1);
      chk($sformatf("stall_cnt%0d", k), dut_cnt(0), h_cnt);
    end
    stall = 0; flush = 0;
    @(negedge clk);
    chk("resume_inst", inst[0], 32'h1000_0018);
    chk("resume_adr", adr[0], 32'h1C);
    chk("resume_cnt", dut_cnt(0), h_cnt + 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_adr", adr[0], 32'h20);
    chk("flush_valid", {31'h0, valid[0]}, 32'h0);
    chk("flush_cnt", dut_cnt(0), h_cnt + 1);
    stall = 1; br_taken = 1; br_pc4 = 32'h100; br_imm16 = 16'h0002;
    @(negedge clk);
    stall = 0; br_taken = 0;
    chk("stbr_adr", adr[0], 32'h108);
    chk("stbr_valid", {31'h0, valid[0]}, 32'h0);
    @(negedge clk);
    chk("stbr_inst", inst[0], 32'h1000_0108);
    chk("stbr_pc4", pc4[0], 32'h10C);
    #1 rst = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_adr%0d", i), adr[i], rpc(i));
      chk($sformatf("arst_inst%0d", i), inst[i], 32'h0);
      chk($sformatf("arst_pc4_%0d", i), pc4[i], 32'h0);
      chk($sformatf("arst_valid%0d", i), {31'h0, valid[i]}, 32'h0);
      chk($sformatf("arst_cnt%0d", i), dut_cnt(i), 32'h0);
    end
    #1 rst = 0;
    @(negedge clk);
    chk("reboot_valid", {31'h0, valid[0]}, 32'h0);
    @(negedge clk);
    chk("refetch_inst", inst[0], 32'h1000_0000);
    chk("refetch_cnt", dut_cnt(0), 32'h1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
